// File: rtl/fabric_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fabric_cfg_pkg
// Description : Shared constants, header field positions and controller
//               state encoding for the frame configuration controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fabric_cfg_pkg;

  // Word that opens a configuration session.
  localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

  // Header command codes.
  localparam logic [3:0] CMD_WRITE  = 4'h1;
  localparam logic [3:0] CMD_DESYNC = 4'hF;

  // Header field bit positions.
  localparam int HDR_CMD_MSB = 31;
  localparam int HDR_CMD_LSB = 28;
  localparam int HDR_COL_MSB = 27;
  localparam int HDR_COL_LSB = 20;
  localparam int HDR_CNT_MSB = 7;
  localparam int HDR_CNT_LSB = 0;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2,
    ST_STROBE = 2'd3
  } cfg_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_strobe_decoder.sv
`default_nettype none
// ============================================================================
// Module      : frame_strobe_decoder
// Description : Binary frame index plus enable to a registered one-hot
//               frame strobe vector. Output is all-zero when not enabled.
// Revision    : 1.0 - initial release
// Ports       :
//   CLK     in   clock, rising edge
//   resetn  in   asynchronous active-low reset
//   en      in   load a one-hot pulse on the next edge
//   idx     in   frame row to pulse
//   strobe  out  registered one-hot strobe (MAX_FRAMES bits)
// ============================================================================
module frame_strobe_decoder #(
  parameter int MAX_FRAMES = 20,
  parameter int IDX_W      = 5
) (
  input  logic                  CLK,
  input  logic                  resetn,
  input  logic                  en,
  input  logic [IDX_W-1:0]      idx,
  output logic [MAX_FRAMES-1:0] strobe
);

  logic [MAX_FRAMES-1:0] w_onehot;
  logic [MAX_FRAMES-1:0] r_strobe;

  for (genvar i = 0; i < MAX_FRAMES; i++) begin : g_bit
    assign w_onehot[i] = en && (idx == IDX_W'(i));
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_strobe <= '0;
    end else begin
      r_strobe <= w_onehot;
    end
  end

  assign strobe = r_strobe;

endmodule
`default_nettype wire

// File: rtl/fabric_frame_config_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fabric_frame_config_ctrl
// Description : Turns a 32-bit bitstream word stream into column-selected
//               frame data writes with one-hot single-cycle frame strobes.
// Revision    : 1.0 - initial release
// Ports       :
//   CLK            in   system clock, rising edge
//   resetn         in   asynchronous active-low reset
//   s_data         in   bitstream word
//   s_valid        in   s_data valid
//   s_ready        out  word accepted this cycle when s_valid is high
//   frame_data     out  frame payload for the selected column
//   col_select     out  column receiving frame_data / frame_strobe
//   frame_strobe   out  one-hot single-cycle write pulse per frame row
//   config_active  out  session open (after SYNC, until DESYNC or error)
//   config_done    out  set by DESYNC, cleared by next SYNC
//   err            out  sticky header error, cleared by next SYNC
// ============================================================================
module fabric_frame_config_ctrl
  import fabric_cfg_pkg::*;
#(
  parameter int          FRAME_BITS  = 32,
  parameter int          MAX_FRAMES  = 20,
  parameter int          NUM_COLUMNS = 16,
  parameter logic [31:0] SYNC_WORD   = DEFAULT_SYNC_WORD
) (
  input  logic                            CLK,
  input  logic                            resetn,
  input  logic [31:0]                     s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic [FRAME_BITS-1:0]           frame_data,
  output logic [$clog2(NUM_COLUMNS)-1:0]  col_select,
  output logic [MAX_FRAMES-1:0]           frame_strobe,
  output logic                            config_active,
  output logic                            config_done,
  output logic                            err
);

  localparam int COL_W = $clog2(NUM_COLUMNS);
  localparam int IDX_W = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam int CNT_W = $clog2(MAX_FRAMES + 1);

  cfg_state_t            r_state;
  logic                  r_ready;
  logic                  r_active;
  logic                  r_done;
  logic                  r_err;
  logic [FRAME_BITS-1:0] r_frame_data;
  logic [COL_W-1:0]      r_col;
  logic [IDX_W-1:0]      r_idx;
  logic [CNT_W-1:0]      r_remaining;

  logic       w_accept;
  logic [3:0] w_cmd;
  logic [7:0] w_col;
  logic [7:0] w_cnt;
  logic       w_hdr_ok;
  logic       w_strobe_en;

  assign w_accept = s_valid && r_ready;
  assign w_cmd    = s_data[HDR_CMD_MSB:HDR_CMD_LSB];
  assign w_col    = s_data[HDR_COL_MSB:HDR_COL_LSB];
  assign w_cnt    = s_data[HDR_CNT_MSB:HDR_CNT_LSB];

  // A WRITE header is usable only if it addresses a real column and asks
  // for 1..MAX_FRAMES frames; this bound also keeps r_idx in range.
  assign w_hdr_ok = (w_cmd == CMD_WRITE) &&
                    (int'(w_col) < NUM_COLUMNS) &&
                    (w_cnt != 8'd0) &&
                    (int'(w_cnt) <= MAX_FRAMES);

  // The strobe register loads on the same edge that captures the data word,
  // so the pulse lands exactly in the following (STROBE) cycle.
  assign w_strobe_en = (r_state == ST_DATA) && w_accept;

  frame_strobe_decoder #(
    .MAX_FRAMES (MAX_FRAMES),
    .IDX_W      (IDX_W)
  ) u_strobe_dec (
    .CLK    (CLK),
    .resetn (resetn),
    .en     (w_strobe_en),
    .idx    (r_idx),
    .strobe (frame_strobe)
  );

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_HUNT;
      r_ready      <= 1'b1;
      r_active     <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_frame_data <= '0;
      r_col        <= '0;
      r_idx        <= '0;
      r_remaining  <= '0;
    end else begin
      case (r_state)
        ST_HUNT: begin
          if (w_accept && (s_data == SYNC_WORD)) begin
            r_state  <= ST_HEADER;
            r_active <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
          end
        end
        ST_HEADER: begin
          if (w_accept) begin
            if (w_cmd == CMD_DESYNC) begin
              r_state  <= ST_HUNT;
              r_active <= 1'b0;
              r_done   <= 1'b1;
            end else if (w_hdr_ok) begin
              r_col       <= w_col[COL_W-1:0];
              r_idx       <= '0;
              r_remaining <= w_cnt[CNT_W-1:0];
              r_state     <= ST_DATA;
            end else begin
              r_err    <= 1'b1;
              r_active <= 1'b0;
              r_state  <= ST_HUNT;
            end
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_frame_data <= s_data[FRAME_BITS-1:0];
            r_ready      <= 1'b0;
            r_state      <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          r_ready <= 1'b1;
          // The index is not advanced past the last frame so it never
          // leaves the 0..MAX_FRAMES-1 range.
          if (r_remaining == CNT_W'(1)) begin
            r_remaining <= '0;
            r_state     <= ST_HEADER;
          end else begin
            r_remaining <= r_remaining - CNT_W'(1);
            r_idx       <= r_idx + IDX_W'(1);
            r_state     <= ST_DATA;
          end
        end
        default: begin
          r_state <= ST_HUNT;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign s_ready       = r_ready;
  assign frame_data    = r_frame_data;
  assign col_select    = r_col;
  assign config_active = r_active;
  assign config_done   = r_done;
  assign err           = r_err;

endmodule
`default_nettype wire
